// File: rtl/alarm_pkg.sv
// rtl/alarm_pkg.sv - shared BCD time type, digit limits and load validation for the alarm bank
package alarm_pkg;

    typedef struct packed {
        logic [3:0] ms_hr;
        logic [3:0] ls_hr;
        logic [3:0] ms_min;
        logic [3:0] ls_min;
    } bcd_time_t;

    localparam logic [3:0] MAX_MS_HR      = 4'd2;
    localparam logic [3:0] MAX_LS_HR_AT_2 = 4'd3;
    localparam logic [3:0] MAX_MS_MIN     = 4'd5;
    localparam logic [3:0] MAX_DIGIT      = 4'd9;

    function automatic logic bcd_time_valid(input bcd_time_t t);
        logic ok;
        ok = (t.ms_hr <= MAX_MS_HR) && (t.ls_hr <= MAX_DIGIT) &&
             (t.ms_min <= MAX_MS_MIN) && (t.ls_min <= MAX_DIGIT);
        if ((t.ms_hr == MAX_MS_HR) && (t.ls_hr > MAX_LS_HR_AT_2)) begin
            ok = 1'b0;
        end
        return ok;
    endfunction

endpackage

// File: rtl/bcd_time_add.sv
// rtl/bcd_time_add.sv - combinational BCD hh:mm plus ADD_MIN minutes with 24-hour wrap
module bcd_time_add
    import alarm_pkg::*;
#(
    parameter int ADD_MIN = 5
) (
    input  bcd_time_t time_i,
    output bcd_time_t sum_o
);

    logic [6:0] min_raw;
    logic [6:0] min_adj;
    logic [6:0] hr_raw;
    logic [6:0] hr_adj;

    always_comb begin
        min_raw = 7'(time_i.ms_min) * 7'd10 + 7'(time_i.ls_min) + 7'(ADD_MIN);
        hr_raw  = 7'(time_i.ms_hr) * 7'd10 + 7'(time_i.ls_hr);
        min_adj = min_raw;
        hr_adj  = hr_raw;
        if (min_raw >= 7'd60) begin
            min_adj = min_raw - 7'd60;
            hr_adj  = hr_raw + 7'd1;
        end
        if (hr_adj >= 7'd24) begin
            hr_adj = hr_adj - 7'd24;
        end
        sum_o.ms_hr  = 4'(hr_adj / 7'd10);
        sum_o.ls_hr  = 4'(hr_adj % 7'd10);
        sum_o.ms_min = 4'(min_adj / 7'd10);
        sum_o.ls_min = 4'(min_adj % 7'd10);
    end

endmodule

// File: rtl/alarm_bank.sv
// rtl/alarm_bank.sv - multi-slot BCD alarm bank with per-slot enable and edge-latched ringing
// Optional snooze adder is built only when ALARM_SNOOZE_EN is defined.
module alarm_bank
    import alarm_pkg::*;
#(
    parameter int NUM_ALARMS = 4,
    parameter int IDX_W      = 2,
    parameter int SNOOZE_MIN = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load_new_alarm,
    input  logic [IDX_W-1:0]      load_idx,
    input  logic [3:0]            new_alarm_ms_hr,
    input  logic [3:0]            new_alarm_ls_hr,
    input  logic [3:0]            new_alarm_ms_min,
    input  logic [3:0]            new_alarm_ls_min,
    input  logic                  enable_wr,
    input  logic                  enable_val,
    input  logic [3:0]            current_time_ms_hr,
    input  logic [3:0]            current_time_ls_hr,
    input  logic [3:0]            current_time_ms_min,
    input  logic [3:0]            current_time_ls_min,
    input  logic                  stop_alarm,
    input  logic                  snooze,
    input  logic [IDX_W-1:0]      rd_idx,
    output logic [3:0]            rd_ms_hr,
    output logic [3:0]            rd_ls_hr,
    output logic [3:0]            rd_ms_min,
    output logic [3:0]            rd_ls_min,
    output logic [NUM_ALARMS-1:0] slot_enabled,
    output logic [NUM_ALARMS-1:0] ringing,
    output logic                  sound_alarm,
    output logic [IDX_W-1:0]      hit_idx,
    output logic                  load_error
);

    bcd_time_t             time_q [NUM_ALARMS];
    bcd_time_t             time_d [NUM_ALARMS];
    logic [NUM_ALARMS-1:0] en_q, en_d;
    logic [NUM_ALARMS-1:0] ring_q, ring_d;
    logic [NUM_ALARMS-1:0] prev_q, prev_d;
    logic                  err_q, err_d;

    logic [NUM_ALARMS-1:0] sel;
    logic [NUM_ALARMS-1:0] match;
    logic                  idx_ok;
    logic                  new_ok;
    bcd_time_t             new_time;
    bcd_time_t             cur_time;
    bcd_time_t             rd_time;
    logic                  snooze_go;
    bcd_time_t             snooze_time;

    assign new_time = {new_alarm_ms_hr, new_alarm_ls_hr, new_alarm_ms_min, new_alarm_ls_min};
    assign cur_time = {current_time_ms_hr, current_time_ls_hr,
                       current_time_ms_min, current_time_ls_min};
    assign new_ok   = bcd_time_valid(new_time);

    // Decoding the index per slot makes an out-of-range index simply select nothing.
    always_comb begin
        for (int i = 0; i < NUM_ALARMS; i++) begin
            sel[i]   = (load_idx == IDX_W'(i));
            match[i] = en_q[i] && (time_q[i] == cur_time);
        end
    end
    assign idx_ok = |sel;

    always_comb begin
        hit_idx = '0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (ring_q[i]) begin
                hit_idx = IDX_W'(i);
            end
        end
    end

    assign sound_alarm  = |ring_q;
    assign ringing      = ring_q;
    assign slot_enabled = en_q;
    assign load_error   = err_q;

`ifdef ALARM_SNOOZE_EN
    bcd_time_t hit_time;

    always_comb begin
        hit_time = '0;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            if (hit_idx == IDX_W'(i)) begin
                hit_time = time_q[i];
            end
        end
    end

    bcd_time_add #(
        .ADD_MIN (SNOOZE_MIN)
    ) u_snooze_add (
        .time_i (hit_time),
        .sum_o  (snooze_time)
    );

    assign snooze_go = snooze && sound_alarm && !stop_alarm;
`else
    logic [7:0] unused_snooze_cfg;

    assign unused_snooze_cfg = {snooze, 7'(SNOOZE_MIN)};
    assign snooze_go         = 1'b0;
    assign snooze_time       = '0;
`endif

    // Priority within a slot: rising match, then disable, snooze, and finally load.
    always_comb begin
        time_d = time_q;
        en_d   = en_q;
        prev_d = match;
        ring_d = (stop_alarm ? '0 : ring_q) | (match & ~prev_q);
        err_d  = (load_new_alarm && (!idx_ok || !new_ok)) || (enable_wr && !idx_ok);
        for (int i = 0; i < NUM_ALARMS; i++) begin
            if (enable_wr && sel[i]) begin
                en_d[i] = enable_val;
                if (!enable_val) begin
                    ring_d[i] = 1'b0;
                end
            end
            if (snooze_go && (hit_idx == IDX_W'(i))) begin
                time_d[i] = snooze_time;
                ring_d[i] = 1'b0;
                prev_d[i] = 1'b0;
            end
            if (load_new_alarm && new_ok && sel[i]) begin
                time_d[i] = new_time;
                ring_d[i] = 1'b0;
                prev_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                time_q[i] <= '0;
            end
            en_q   <= '0;
            ring_q <= '0;
            prev_q <= '0;
            err_q  <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_ALARMS; i++) begin
                time_q[i] <= time_d[i];
            end
            en_q   <= en_d;
            ring_q <= ring_d;
            prev_q <= prev_d;
            err_q  <= err_d;
        end
    end

    always_comb begin
        rd_time = '0;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            if (rd_idx == IDX_W'(i)) begin
                rd_time = time_q[i];
            end
        end
    end

    assign rd_ms_hr  = rd_time.ms_hr;
    assign rd_ls_hr  = rd_time.ls_hr;
    assign rd_ms_min = rd_time.ms_min;
    assign rd_ls_min = rd_time.ls_min;

endmodule

// File: doc/alarm_bank.md
# alarm_bank

- Multi-slot successor to the single alarm register: NUM_ALARMS independently loadable, enable-gated alarm times in BCD hh:mm.
- Validates every load, compares all enabled slots against the running clock time, and latches a ringing request per slot.
- Drives sound_alarm with a lowest-index-first hit_idx.
- Sits between the keypad/time-entry logic and the alarm output driver.

## Interface
Parameters:
- NUM_ALARMS, 4, number of alarm slots (1..16)
- IDX_W, 2, slot index width, equals clog2(NUM_ALARMS), minimum 1
- SNOOZE_MIN, 5, snooze offset in minutes (1..59, binary)

Ports:
- clock  input  1  single clock, all state on rising edge
- reset  input  1  asynchronous, active-high; clears all state
- load_new_alarm  input  1  write new_alarm_* into slot load_idx
- load_idx  input  IDX_W  target slot for load/enable writes
- new_alarm_ms_hr, new_alarm_ls_hr, new_alarm_ms_min, new_alarm_ls_min  input  4 each  BCD digits of new time
- enable_wr  input  1  write enable_val to slot load_idx enable bit
- enable_val  input  1  enable bit value
- current_time_ms_hr, current_time_ls_hr, current_time_ms_min, current_time_ls_min  input  4 each  running BCD time
- stop_alarm  input  1  clear all ringing flags
- snooze  input  1  snooze the slot at hit_idx (only with ALARM_SNOOZE_EN)
- rd_idx  input  IDX_W  readback slot select
- rd_ms_hr, rd_ls_hr, rd_ms_min, rd_ls_min  output  4 each  combinational readback of slot rd_idx
- slot_enabled  output  NUM_ALARMS  registered enable bits
- ringing  output  NUM_ALARMS  registered per-slot ring flags
- sound_alarm  output  1  OR of ringing
- hit_idx  output  IDX_W  lowest index with ringing set; 0 when none
- load_error  output  1  one-cycle pulse on a rejected load

## Operation
- Reset values: all slot times 00:00, slot_enabled 0, ringing 0, load_error 0, internal previous-match bits 0. hit_idx and sound_alarm are therefore 0.
- Load validation: a load is accepted only if all of the following hold:
  - every digit ≤ 9
  - ms_hr ≤ 2; if ms_hr = 2 then ls_hr ≤ 3
  - ms_min ≤ 5
- Rejected load: slot is unchanged, load_error pulses the next cycle.
- load_idx ≥ NUM_ALARMS: load and enable writes are ignored and load_error pulses.
- An accepted load does not change that slot's enable bit.
- match[i] = slot_enabled[i] AND stored time[i] equals the current time, comparing all 4 digits.
- ringing[i] sets on the rising edge of match[i], i.e. match now and prev_match[i] was 0. An alarm fires once per minute of match, not every cycle.
- stop_alarm clears all ringing bits.
- A new rising match in the same cycle as stop_alarm wins: that bit ends the cycle set.
- enable_wr with enable_val=0 also clears ringing for that slot.
- Load to a slot clears that slot's ringing and its prev_match.
- Load and match on the same slot in the same cycle: the compare uses the old stored value; the load then clears ringing. The load wins.

## Timing
- Load and enable writes: visible on outputs/readback one cycle after the edge.
- Ringing, sound_alarm, hit_idx: one cycle after current time becomes equal to an enabled slot.
- load_error: asserted exactly one cycle after the offending edge.
- Readback rd_*: combinational from stored state, no added latency.
- Reset is asynchronous: any in-progress ring or snooze is discarded immediately.

## Configuration
- Macro: ALARM_SNOOZE_EN.
- Defined:
  - snooze while sound_alarm=1 clears ringing[hit_idx] and adds SNOOZE_MIN to that slot's stored time.
  - Addition is BCD minutes with carry into hours; 23:5x wraps to 00:0x.
  - The slot's prev_match is cleared.
  - snooze with sound_alarm=0 is ignored.
  - snooze and stop_alarm in the same cycle: stop wins and the time is unchanged.
- Undefined: the snooze input is ignored, and no adder logic is synthesised.

## Structure
- Shared package alarm_pkg:
  - bcd_time_t typedef (4×4-bit digits)
  - constants MAX_MS_HR=2, MAX_LS_HR_AT_2=3, MAX_MS_MIN=5
  - function bcd_time_valid
- Sub-module bcd_time_add: combinational BCD hh:mm + N-minute adder with 24-hour wrap, used only under ALARM_SNOOZE_EN.

## Test plan
- Reset, then read all slots → every rd_* = 0, slot_enabled=0, sound_alarm=0.
- Load slot 2 = 07:30 and enable it; drive current time 07:30 for 10 cycles → ringing=4'b0100 and sound_alarm=1 from cycle 1 onward, rising once. stop_alarm at cycle 5 → cleared, no refire while time stays 07:30.
- Load 24:00, then 12:60, then digit 4'hA → each rejected with a load_error pulse, slot unchanged. Load 23:59 → accepted.
- Slots 1 and 3 both 06:00 and enabled, time reaches 06:00 → ringing=4'b1010, hit_idx=1. Stop, then reload slot 1 → hit_idx tracks correctly.
- With ALARM_SNOOZE_EN: slot 0 = 23:58 rings, snooze → slot 0 reads 00:03, ringing clears, and it rings again when time = 00:03.
- Async reset while slot 0 is ringing → all outputs 0 immediately, before the next clock edge.
